// File: rtl/seq_ctrl.sv
// Table-driven pattern sequencer: steps (pattern, dwell) entries in loop,
// one-shot or ping-pong order, with pause, clear and wrap/done status pulses.
module seq_ctrl #(
    parameter int BW_SEQ     = 6,
    parameter int SEQ_CNT    = 6,
    parameter int BW_SEQ_CNT = 3,
    parameter int BW_TIMEOUT = 3,
    parameter logic [BW_SEQ-1:0] RV = 6'b000001
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic                                      CLR,
    input  logic                                      START,
    input  logic                                      PAUSE,
    input  logic [1:0]                                MODE,
    input  logic [BW_SEQ_CNT-1:0]                     LAST,
    input  logic [SEQ_CNT*(BW_SEQ+BW_TIMEOUT)-1:0]    PTN,
    output logic [BW_SEQ-1:0]                         SEQ,
    output logic [BW_SEQ_CNT-1:0]                     IDX,
    output logic                                      BUSY,
    output logic                                      DONE,
    output logic                                      WRAP
);

    localparam int EW = BW_SEQ + BW_TIMEOUT;
    localparam logic [BW_SEQ_CNT-1:0] IDX_ZERO = {BW_SEQ_CNT{1'b0}};
    localparam logic [BW_SEQ_CNT-1:0] IDX_ONE  = BW_SEQ_CNT'(1);
    localparam logic [BW_SEQ_CNT-1:0] IDX_MAX  = BW_SEQ_CNT'(SEQ_CNT - 1);
    localparam logic [BW_TIMEOUT-1:0] CNT_ZERO = {BW_TIMEOUT{1'b0}};
    localparam logic [BW_TIMEOUT-1:0] CNT_ONE  = BW_TIMEOUT'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_r;
    logic [1:0]              mode_r;
    logic [BW_SEQ_CNT-1:0]   last_r;
    logic [BW_SEQ_CNT-1:0]   idx_r;
    logic [BW_TIMEOUT-1:0]   cnt_r;
    logic                    dir_up_r;
    logic [BW_SEQ-1:0]       seq_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    wrap_r;

    logic [BW_SEQ_CNT-1:0]   nxt_idx_s;
    logic                    nxt_dir_up_s;
    logic                    step_wrap_s;
    logic                    step_done_s;
    logic [BW_SEQ_CNT-1:0]   last_clamp_s;
    logic [EW-1:0]           first_entry_s;
    logic [EW-1:0]           nxt_entry_s;

    // Entry 0 sits in the MSBs of the table; out-of-range indices read as zero.
    function automatic logic [EW-1:0] entry_at(input logic [SEQ_CNT*EW-1:0] tbl,
                                               input logic [BW_SEQ_CNT-1:0] idx);
        logic [EW-1:0] e;
        e = {EW{1'b0}};
        for (int i = 0; i < SEQ_CNT; i++) begin
            e = (idx == BW_SEQ_CNT'(i)) ? tbl[(SEQ_CNT-1-i)*EW +: EW] : e;
        end
        return e;
    endfunction

    assign last_clamp_s  = (LAST > IDX_MAX) ? IDX_MAX : LAST;
    assign first_entry_s = entry_at(PTN, IDX_ZERO);
    assign nxt_entry_s   = entry_at(PTN, nxt_idx_s);

    // Successor entry, direction and pulse flags for when the current dwell expires.
    always_comb begin
        nxt_idx_s    = idx_r;
        nxt_dir_up_s = dir_up_r;
        step_wrap_s  = 1'b0;
        step_done_s  = 1'b0;
        case (mode_r)
            2'd1: begin
                if (idx_r == last_r) begin
                    step_done_s = 1'b1;
                end else begin
                    nxt_idx_s = idx_r + IDX_ONE;
                end
            end
            2'd2: begin
                // Reversal steps straight to the neighbour so end entries are not doubled.
                if (last_r == IDX_ZERO) begin
                    nxt_idx_s   = IDX_ZERO;
                    step_wrap_s = 1'b1;
                end else if (dir_up_r) begin
                    if (idx_r == last_r) begin
                        nxt_dir_up_s = 1'b0;
                        nxt_idx_s    = idx_r - IDX_ONE;
                        step_wrap_s  = 1'b1;
                    end else begin
                        nxt_idx_s = idx_r + IDX_ONE;
                    end
                end else begin
                    if (idx_r == IDX_ZERO) begin
                        nxt_dir_up_s = 1'b1;
                        nxt_idx_s    = IDX_ONE;
                        step_wrap_s  = 1'b1;
                    end else begin
                        nxt_idx_s = idx_r - IDX_ONE;
                    end
                end
            end
            default: begin
                if (idx_r == last_r) begin
                    nxt_idx_s   = IDX_ZERO;
                    step_wrap_s = 1'b1;
                end else begin
                    nxt_idx_s = idx_r + IDX_ONE;
                end
            end
        endcase
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            state_r  <= ST_IDLE;
            mode_r   <= 2'd0;
            last_r   <= IDX_ZERO;
            idx_r    <= IDX_ZERO;
            cnt_r    <= CNT_ZERO;
            dir_up_r <= 1'b1;
            seq_r    <= RV;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            wrap_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            wrap_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        state_r  <= ST_RUN;
                        mode_r   <= MODE;
                        last_r   <= last_clamp_s;
                        idx_r    <= IDX_ZERO;
                        dir_up_r <= 1'b1;
                        seq_r    <= first_entry_s[EW-1:BW_TIMEOUT];
                        cnt_r    <= first_entry_s[BW_TIMEOUT-1:0];
                        busy_r   <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (PAUSE) begin
                        state_r <= ST_RUN;
                    end else if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else if (step_done_s) begin
                        state_r  <= ST_IDLE;
                        idx_r    <= IDX_ZERO;
                        dir_up_r <= 1'b1;
                        seq_r    <= RV;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                    end else begin
                        idx_r    <= nxt_idx_s;
                        dir_up_r <= nxt_dir_up_s;
                        seq_r    <= nxt_entry_s[EW-1:BW_TIMEOUT];
                        cnt_r    <= nxt_entry_s[BW_TIMEOUT-1:0];
                        wrap_r   <= step_wrap_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    seq_r   <= RV;
                    idx_r   <= IDX_ZERO;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign SEQ  = seq_r;
    assign IDX  = idx_r;
    assign BUSY = busy_r;
    assign DONE = done_r;
    assign WRAP = wrap_r;

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: directed scenarios plus random traffic,
// compared cycle by cycle against a visit-order reference model.
module tb_seq_ctrl;

    localparam int SEQ_CNT = 6;
    localparam logic [5:0] RV = 6'b000001;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CLR = 1'b0;
    logic        START = 1'b0;
    logic        PAUSE = 1'b0;
    logic [1:0]  MODE = 2'd0;
    logic [2:0]  LAST = 3'd0;
    logic [53:0] PTN = 54'd0;
    logic [5:0]  SEQ;
    logic [2:0]  IDX;
    logic        BUSY, DONE, WRAP;

    int nvec = 0;
    int nerr = 0;

    logic [5:0] pat [SEQ_CNT];
    logic [2:0] dw  [SEQ_CNT];

    // reference model state
    bit         m_run = 1'b0;
    int         m_mode, m_last, m_pos, m_rem;
    bit         m_left;
    int         m_order[$];
    logic [5:0] e_seq = 6'b000001;
    int         e_idx = 0;
    bit         e_busy = 1'b0, e_done = 1'b0, e_wrap = 1'b0;
    logic [11:0] got, exp_v;

    seq_ctrl dut (
        .CLK(CLK), .RST(RST), .CLR(CLR), .START(START), .PAUSE(PAUSE),
        .MODE(MODE), .LAST(LAST), .PTN(PTN),
        .SEQ(SEQ), .IDX(IDX), .BUSY(BUSY), .DONE(DONE), .WRAP(WRAP)
    );

    always #5 CLK = ~CLK;

    function automatic void pack_table();
        for (int i = 0; i < SEQ_CNT; i++) PTN[(SEQ_CNT-1-i)*9 +: 9] = {pat[i], dw[i]};
    endfunction

    function automatic void onehot_table(input bit zero_dwell);
        for (int i = 0; i < SEQ_CNT; i++) begin
            pat[i] = 6'(1 << i);
            dw[i]  = zero_dwell ? 3'd0 : 3'(i);
        end
        pack_table();
    endfunction

    function automatic void go_idle();
        m_run = 1'b0; e_seq = RV; e_idx = 0; e_busy = 1'b0; m_rem = 0;
    endfunction

    function automatic void load_entry();
        e_idx = m_order[m_pos];
        e_seq = pat[e_idx];
        m_rem = int'(dw[e_idx]) + 1;
    endfunction

    // Model: a run is a list of entry indices visited in order, each held dwell+1 cycles.
    function automatic void model_edge();
        int e;
        e_done = 1'b0; e_wrap = 1'b0;
        if (RST || CLR) begin
            go_idle();
        end else if (!m_run) begin
            if (START) begin
                m_mode = int'(MODE);
                m_last = (int'(LAST) > SEQ_CNT-1) ? SEQ_CNT-1 : int'(LAST);
                m_order.delete();
                for (int i = 0; i <= m_last; i++) m_order.push_back(i);
                if (m_mode == 2) for (int i = m_last-1; i >= 1; i--) m_order.push_back(i);
                m_pos = 0; m_left = 1'b0; m_run = 1'b1; e_busy = 1'b1;
                load_entry();
            end
        end else if (!PAUSE) begin
            m_rem--;
            if (m_rem == 0) begin
                e = m_order[m_pos];
                if (m_mode == 1 && e == m_last) begin
                    go_idle();
                    e_done = 1'b1;
                end else begin
                    if (m_mode == 2) e_wrap = (e == m_last) || (e == 0 && m_left);
                    else             e_wrap = (e == m_last);
                    m_left = 1'b1;
                    m_pos = (m_pos + 1) % m_order.size();
                    load_entry();
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        got   = {SEQ, IDX, BUSY, DONE, WRAP};
        exp_v = {e_seq, 3'(e_idx), e_busy, e_done, e_wrap};
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++;
            if (got !== exp_v || got !== {RV, 3'd0, 3'b000}) begin
                nerr++;
                $display("FAIL reset: got seq/idx/busy/done/wrap=%b exp %b", got, exp_v);
            end
        end
        RST = 1'b0;
    endtask

    task automatic test_loop();
        int wraps = 0;
        onehot_table(1'b0);
        MODE = 2'd0; LAST = 3'd5; START = 1'b1;
        for (int c = 0; c < 46; c++) begin
            tick();
            START = 1'b0;
            if (c >= 1 && c <= 42 && WRAP) wraps++;
            nvec++;
            if (got !== exp_v) begin
                nerr++;
                $display("FAIL loop cyc %0d: got %b exp %b", c, got, exp_v);
            end
        end
        nvec++;
        if (wraps !== 2) begin
            nerr++;
            $display("FAIL loop_period: got %0d wraps in 42 cycles exp 2", wraps);
        end
        CLR = 1'b1; tick(); CLR = 1'b0;
    endtask

    task automatic test_oneshot();
        int dones = 0, wraps = 0;
        onehot_table(1'b0);
        MODE = 2'd1; LAST = 3'd2; START = 1'b1;
        tick(); START = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (DONE) dones++;
            if (WRAP) wraps++;
            nvec++;
            if (got !== exp_v) begin
                nerr++;
                $display("FAIL oneshot cyc %0d: got %b exp %b", c, got, exp_v);
            end
        end
        nvec++;
        if (dones !== 1 || wraps !== 0) begin
            nerr++;
            $display("FAIL oneshot_pulses: got done=%0d wrap=%0d exp done=1 wrap=0", dones, wraps);
        end
        // START held high across completion: restart one edge later
        START = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tick();
            nvec++;
            if (got !== exp_v) begin
                nerr++;
                $display("FAIL oneshot_hold cyc %0d: got %b exp %b", c, got, exp_v);
            end
        end
        START = 1'b0; CLR = 1'b1; tick(); CLR = 1'b0;
    endtask

    task automatic test_pingpong();
        logic [2:0] lasts [3];
        lasts[0] = 3'd3; lasts[1] = 3'd1; lasts[2] = 3'd0;
        onehot_table(1'b1);
        for (int k = 0; k < 3; k++) begin
            MODE = 2'd2; LAST = lasts[k]; START = 1'b1;
            for (int c = 0; c < 16; c++) begin
                tick();
                START = 1'b0;
                nvec++;
                if (got !== exp_v) begin
                    nerr++;
                    $display("FAIL pingpong last=%0d cyc %0d: got %b exp %b", lasts[k], c, got, exp_v);
                end
            end
            CLR = 1'b1; tick(); CLR = 1'b0;
        end
    endtask

    task automatic test_pause();
        int hold = 0;
        onehot_table(1'b0);
        MODE = 2'd0; LAST = 3'd5; START = 1'b1;
        for (int c = 0; c < 22; c++) begin
            PAUSE = (c >= 8 && c < 12);
            tick();
            START = 1'b0;
            if (SEQ == 6'b001000 && IDX == 3'd3) hold++;
            nvec++;
            if (got !== exp_v) begin
                nerr++;
                $display("FAIL pause cyc %0d: got %b exp %b", c, got, exp_v);
            end
        end
        PAUSE = 1'b0;
        nvec++;
        if (hold !== 8) begin
            nerr++;
            $display("FAIL pause_hold: got %0d cycles on entry 3 exp 8", hold);
        end
        CLR = 1'b1; tick(); CLR = 1'b0;
    endtask

    task automatic test_abort();
        onehot_table(1'b0);
        for (int k = 0; k < 2; k++) begin
            MODE = 2'd1; LAST = 3'd5; START = 1'b1;
            for (int c = 0; c < 18; c++) begin
                if (c == 12) begin
                    if (k == 0) CLR = 1'b1; else RST = 1'b1;
                end else begin
                    CLR = 1'b0; RST = 1'b0;
                end
                tick();
                START = (c == 14);
                nvec++;
                if (got !== exp_v) begin
                    nerr++;
                    $display("FAIL abort%0d cyc %0d: got %b exp %b", k, c, got, exp_v);
                end
            end
            CLR = 1'b1; tick(); CLR = 1'b0;
        end
    endtask

    task automatic test_last_limits();
        logic [2:0] lasts [3];
        logic [1:0] modes [3];
        lasts[0] = 3'd7; modes[0] = 2'd0;
        lasts[1] = 3'd0; modes[1] = 2'd0;
        lasts[2] = 3'd6; modes[2] = 2'd3;
        onehot_table(1'b0);
        for (int k = 0; k < 3; k++) begin
            MODE = modes[k]; LAST = lasts[k]; START = 1'b1;
            for (int c = 0; c < 30; c++) begin
                tick();
                START = 1'b0;
                nvec++;
                if (got !== exp_v) begin
                    nerr++;
                    $display("FAIL last=%0d mode=%0d cyc %0d: got %b exp %b", lasts[k], modes[k], c, got, exp_v);
                end
            end
            CLR = 1'b1; tick(); CLR = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < SEQ_CNT; i++) begin
            pat[i] = 6'($urandom_range(63, 0));
            dw[i]  = 3'($urandom_range(7, 0));
        end
        pack_table();
        for (int c = 0; c < 2000; c++) begin
            START = ($urandom_range(99, 0) < 30);
            PAUSE = ($urandom_range(99, 0) < 20);
            CLR   = ($urandom_range(99, 0) < 2);
            RST   = ($urandom_range(999, 0) < 5);
            MODE  = 2'($urandom_range(3, 0));
            LAST  = 3'($urandom_range(7, 0));
            tick();
            nvec++;
            if (got !== exp_v) begin
                nerr++;
                $display("FAIL random cyc %0d: got %b exp %b", c, got, exp_v);
            end
        end
        START = 1'b0; PAUSE = 1'b0; CLR = 1'b0; RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_loop();
        test_oneshot();
        test_pingpong();
        test_pause();
        test_abort();
        test_last_limits();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
